// File: rtl/axi_chan_throttle.sv
// axi_chan_throttle: per-lane 2-entry skid buffer with LFSR-driven ready/valid stall injection.
// Define THROTTLE_STATS_EN to build the per-lane saturating upstream stall counters.
module axi_chan_throttle #(
   parameter int unsigned NUM_CH   = 7,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned IN_PROB  = 1024,
   parameter int unsigned OUT_PROB = 1024,
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     enable,
   input  logic [NUM_CH-1:0]        s_valid,
   output logic [NUM_CH-1:0]        s_ready,
   input  logic [NUM_CH*DATA_W-1:0] s_data,
   output logic [NUM_CH-1:0]        m_valid,
   input  logic [NUM_CH-1:0]        m_ready,
   output logic [NUM_CH*DATA_W-1:0] m_data,
   output logic [NUM_CH*CNT_W-1:0]  stall_cnt
);

   localparam logic [10:0] InProbW  = 11'(IN_PROB);
   localparam logic [10:0] OutProbW = 11'(OUT_PROB);
   localparam logic [15:0] LfsrTaps = 16'hB400;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      // An all-zero seed would lock the LFSR up.
      localparam logic [15:0] SeedX    = SEED ^ 16'(c + 1);
      localparam logic [15:0] LaneSeed = (SeedX == 16'h0000) ? 16'h0001 : SeedX;

      logic [15:0]       lfsr_q, lfsr_d;
      logic              in_gate_q, out_gate_q;
      logic [1:0]        count_q, count_d;
      logic              head_q, tail_q, hold_q;
      logic [DATA_W-1:0] mem_q [2];
      logic              push, pop;

      assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
      assign s_ready[c] = (count_q != 2'd2) & in_gate_q;
      // hold keeps VALID up once offered, regardless of the output gate.
      assign m_valid[c] = (count_q != 2'd0) & (out_gate_q | hold_q);
      assign m_data[c*DATA_W +: DATA_W] = mem_q[head_q];
      assign push       = s_valid[c] & s_ready[c];
      assign pop        = m_valid[c] & m_ready[c];

      always_comb begin
         count_d = count_q;
         if (push && !pop) begin
            count_d = count_q + 2'd1;
         end else if (pop && !push) begin
            count_d = count_q - 2'd1;
         end
      end

      always_ff @(posedge clk) begin
         if (!rstn) begin
            lfsr_q     <= LaneSeed;
            in_gate_q  <= 1'b0;
            out_gate_q <= 1'b0;
            count_q    <= 2'd0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            hold_q     <= 1'b0;
         end else begin
            lfsr_q     <= lfsr_d;
            in_gate_q  <= !enable | ({1'b0, lfsr_q[9:0]} < InProbW);
            out_gate_q <= !enable | ({1'b0, lfsr_q[15:6]} < OutProbW);
            count_q    <= count_d;
            if (push) begin
               tail_q <= !tail_q;
            end
            if (pop) begin
               head_q <= !head_q;
               hold_q <= 1'b0;
            end else if (m_valid[c]) begin
               hold_q <= 1'b1;
            end
         end
      end

      // Payload storage needs no reset; count gates its visibility.
      always_ff @(posedge clk) begin
         if (push) begin
            mem_q[tail_q] <= s_data[c*DATA_W +: DATA_W];
         end
      end

`ifdef THROTTLE_STATS_EN
      logic [CNT_W-1:0] stall_q;

      always_ff @(posedge clk) begin
         if (!rstn) begin
            stall_q <= '0;
         end else if (s_valid[c] && !s_ready[c] && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
      end

      assign stall_cnt[c*CNT_W +: CNT_W] = stall_q;
`else
      assign stall_cnt[c*CNT_W +: CNT_W] = '0;
`endif
   end

endmodule

// File: tb/tb_axi_chan_throttle.sv
// Directed self-checking bench for axi_chan_throttle: three instances cover the open-gate,
// half-probability and blocked-input configurations.
module tb_axi_chan_throttle;

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 4;
   localparam int          NR = 2000;
`ifdef THROTTLE_STATS_EN
   localparam bit StatsEn = 1'b1;
`else
   localparam bit StatsEn = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;
   int   total = 0;
   int   bad   = 0;

   logic          en_a, en_r, en_z;
   logic [1:0]    sv_a, sr_a, mv_a, mr_a, sv_r, sr_r, mv_r, mr_r;
   logic [2*DW-1:0] sd_a, md_a, sd_r, md_r;
   logic [2*CW-1:0] sc_a, sc_r;
   logic [0:0]    sv_z, sr_z, mv_z, mr_z;
   logic [7:0]    sd_z, md_z;
   logic [CW-1:0] sc_z;

   axi_chan_throttle #(.NUM_CH(2), .DATA_W(DW), .IN_PROB(1024), .OUT_PROB(1024),
                       .SEED(16'hACE1), .CNT_W(CW)) u_a (
      .clk(clk), .rstn(rstn), .enable(en_a), .s_valid(sv_a), .s_ready(sr_a), .s_data(sd_a),
      .m_valid(mv_a), .m_ready(mr_a), .m_data(md_a), .stall_cnt(sc_a));

   axi_chan_throttle #(.NUM_CH(2), .DATA_W(DW), .IN_PROB(512), .OUT_PROB(512),
                       .SEED(16'hACE1), .CNT_W(CW)) u_r (
      .clk(clk), .rstn(rstn), .enable(en_r), .s_valid(sv_r), .s_ready(sr_r), .s_data(sd_r),
      .m_valid(mv_r), .m_ready(mr_r), .m_data(md_r), .stall_cnt(sc_r));

   axi_chan_throttle #(.NUM_CH(1), .DATA_W(8), .IN_PROB(0), .OUT_PROB(1024),
                       .SEED(16'h1234), .CNT_W(CW)) u_z (
      .clk(clk), .rstn(rstn), .enable(en_z), .s_valid(sv_z), .s_ready(sr_z), .s_data(sd_z),
      .m_valid(mv_z), .m_ready(mr_z), .m_data(md_z), .stall_cnt(sc_z));

   task automatic test_reset();
      rstn = 1'b0;
      en_a = 1'b0; sv_a = '0; mr_a = '0; sd_a = '0;
      en_r = 1'b1; sv_r = '0; mr_r = '0; sd_r = '0;
      en_z = 1'b1; sv_z = '0; mr_z = '0; sd_z = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (sr_a !== 2'b00) begin bad++; $display("FAIL reset_s_ready_a got=%b exp=00", sr_a); end
      total++; if (mv_a !== 2'b00) begin bad++; $display("FAIL reset_m_valid_a got=%b exp=00", mv_a); end
      total++; if (sc_a !== '0) begin bad++; $display("FAIL reset_stall_a got=%0h exp=0", sc_a); end
      total++; if (mv_r !== 2'b00) begin bad++; $display("FAIL reset_m_valid_r got=%b exp=00", mv_r); end
      total++; if (sr_z !== 1'b0) begin bad++; $display("FAIL reset_s_ready_z got=%b exp=0", sr_z); end
      total++; if (sc_z !== '0) begin bad++; $display("FAIL reset_stall_z got=%0h exp=0", sc_z); end
      rstn = 1'b1;
   endtask

   // enable=0: 100 beats, one per cycle, 1-cycle latency, continuous m_valid.
   task automatic test_stream();
      int sent = 0;
      int rcv = 0;
      en_a = 1'b0;
      mr_a[0] = 1'b1;
      for (int cyc = 0; cyc < 110 && rcv < 100; cyc++) begin
         @(negedge clk);
         total++;
         if (sr_a[0] !== 1'b1) begin
            bad++; $display("FAIL stream_s_ready cyc=%0d got=%b exp=1", cyc, sr_a[0]);
         end
         if (sent > 0) begin
            total++;
            if (mv_a[0] !== 1'b1 || md_a[DW-1:0] !== 16'(16'hA500 + rcv)) begin
               bad++;
               $display("FAIL stream_data cyc=%0d got=%b/%h exp=1/%h", cyc, mv_a[0], md_a[DW-1:0],
                        16'(16'hA500 + rcv));
            end
            rcv++;
         end
         if (sent < 100) begin
            sv_a[0] = 1'b1;
            sd_a[DW-1:0] = 16'(16'hA500 + sent);
            sent++;
         end else begin
            sv_a[0] = 1'b0;
         end
      end
      @(negedge clk);
      total++; if (rcv !== 100) begin bad++; $display("FAIL stream_count got=%0d exp=100", rcv); end
      total++; if (mv_a[0] !== 1'b0) begin bad++; $display("FAIL stream_tail_valid got=%b exp=0", mv_a[0]); end
   endtask

   // m_ready held low on lane 1: exactly two beats accepted, first beat held on m_data.
   task automatic test_backpressure();
      int acc = 0;
      en_a = 1'b1;
      mr_a[1] = 1'b0;
      sv_a[1] = 1'b1;
      sd_a[DW +: DW] = 16'h1000;
      for (int cyc = 0; cyc < 20; cyc++) begin
         total++;
         if (sr_a[1] !== 1'(cyc < 2)) begin
            bad++; $display("FAIL bp_s_ready cyc=%0d got=%b exp=%b", cyc, sr_a[1], cyc < 2);
         end
         if (cyc >= 1) begin
            total++;
            if (mv_a[1] !== 1'b1 || md_a[DW +: DW] !== 16'h1000) begin
               bad++;
               $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/1000", cyc, mv_a[1], md_a[DW +: DW]);
            end
         end
         if (sr_a[1] === 1'b1) acc++;
         @(negedge clk);
         sd_a[DW +: DW] = 16'(16'h1000 + acc);
      end
      total++; if (acc !== 2) begin bad++; $display("FAIL bp_accepted got=%0d exp=2", acc); end
      sv_a[1] = 1'b0;
      mr_a[1] = 1'b1;
      total++;
      if (md_a[DW +: DW] !== 16'h1000) begin
         bad++; $display("FAIL bp_drain0 got=%h exp=1000", md_a[DW +: DW]);
      end
      @(negedge clk);
      total++;
      if (mv_a[1] !== 1'b1 || md_a[DW +: DW] !== 16'h1001) begin
         bad++; $display("FAIL bp_drain1 got=%b/%h exp=1/1001", mv_a[1], md_a[DW +: DW]);
      end
      @(negedge clk);
      total++; if (mv_a[1] !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", mv_a[1]); end
   endtask

   // One beat parked, then 50 cycles of simultaneous push and pop.
   task automatic test_push_pop();
      en_a = 1'b1;
      mr_a[0] = 1'b0;
      sv_a[0] = 1'b1;
      sd_a[DW-1:0] = 16'h3000;
      @(negedge clk);
      total++;
      if (mv_a[0] !== 1'b1 || md_a[DW-1:0] !== 16'h3000) begin
         bad++; $display("FAIL pp_first got=%b/%h exp=1/3000", mv_a[0], md_a[DW-1:0]);
      end
      mr_a[0] = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         sd_a[DW-1:0] = 16'(16'h3000 + k);
         @(negedge clk);
         total++;
         if (sr_a[0] !== 1'b1 || mv_a[0] !== 1'b1 || md_a[DW-1:0] !== 16'(16'h3000 + k)) begin
            bad++;
            $display("FAIL pp_step k=%0d got=%b/%b/%h exp=1/1/%h", k, sr_a[0], mv_a[0],
                     md_a[DW-1:0], 16'(16'h3000 + k));
         end
      end
      sv_a[0] = 1'b0;
      @(negedge clk);
      total++; if (mv_a[0] !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b exp=0", mv_a[0]); end
   endtask

   // Reset with two beats buffered: they vanish and the first post-reset beat is new data.
   task automatic test_reset_mid();
      mr_a[1] = 1'b0;
      sv_a[1] = 1'b1;
      sd_a[DW +: DW] = 16'h2000;
      @(negedge clk);
      sd_a[DW +: DW] = 16'h2001;
      @(negedge clk);
      total++; if (mv_a[1] !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%b exp=1", mv_a[1]); end
      rstn = 1'b0;
      sd_a[DW +: DW] = 16'h2100;
      @(negedge clk);
      total++; if (mv_a[1] !== 1'b0) begin bad++; $display("FAIL rm_m_valid got=%b exp=0", mv_a[1]); end
      total++; if (sr_a[1] !== 1'b0) begin bad++; $display("FAIL rm_s_ready got=%b exp=0", sr_a[1]); end
      total++; if (sc_a !== '0) begin bad++; $display("FAIL rm_stall got=%0h exp=0", sc_a); end
      rstn = 1'b1;
      mr_a[1] = 1'b1;
      @(negedge clk);
      total++;
      if (sr_a[1] !== 1'b1 || mv_a[1] !== 1'b0) begin
         bad++; $display("FAIL rm_reopen got=%b/%b exp=1/0", sr_a[1], mv_a[1]);
      end
      @(negedge clk);
      total++;
      if (mv_a[1] !== 1'b1 || md_a[DW +: DW] !== 16'h2100) begin
         bad++; $display("FAIL rm_new_data got=%b/%h exp=1/2100", mv_a[1], md_a[DW +: DW]);
      end
      sv_a[1] = 1'b0;
      @(negedge clk);
      total++; if (mv_a[1] !== 1'b0) begin bad++; $display("FAIL rm_empty got=%b exp=0", mv_a[1]); end
   endtask

   // Half-probability gates with random m_ready: ordering, VALID/data stability, accept rate.
   task automatic test_random();
      int sent[2] = '{0, 0};
      int rcv[2] = '{0, 0};
      int ready_cnt = 0;
      int open_cnt = 0;
      logic [1:0] prev_stall = 2'b00;
      logic [DW-1:0] prev_data[2];
      logic [DW-1:0] d;
      en_r = 1'b1;
      for (int cyc = 0; cyc < 40000 && (rcv[0] < NR || rcv[1] < NR); cyc++) begin
         for (int l = 0; l < 2; l++) begin
            d = md_r[l*DW +: DW];
            if (prev_stall[l]) begin
               total++;
               if (mv_r[l] !== 1'b1 || d !== prev_data[l]) begin
                  bad++;
                  $display("FAIL rnd_stable lane=%0d cyc=%0d got=%b/%h exp=1/%h", l, cyc, mv_r[l], d,
                           prev_data[l]);
               end
            end
            if (sent[l] - rcv[l] == 2) begin
               total++;
               if (sr_r[l] !== 1'b0) begin
                  bad++; $display("FAIL rnd_full_ready lane=%0d cyc=%0d got=%b exp=0", l, cyc, sr_r[l]);
               end
            end else begin
               open_cnt++;
               if (sr_r[l] === 1'b1) ready_cnt++;
            end
            sv_r[l] = (sent[l] < NR) ? ($urandom_range(0, 3) != 0) : 1'b0;
            mr_r[l] = 1'($urandom_range(0, 1));
            sd_r[l*DW +: DW] = 16'(l * 16'h8000 + sent[l]);
            if (mv_r[l] === 1'b1 && mr_r[l] === 1'b1) begin
               total++;
               if (d !== 16'(l * 16'h8000 + rcv[l])) begin
                  bad++;
                  $display("FAIL rnd_order lane=%0d got=%h exp=%h", l, d, 16'(l * 16'h8000 + rcv[l]));
               end
               rcv[l]++;
            end
            if (sv_r[l] === 1'b1 && sr_r[l] === 1'b1) sent[l]++;
            prev_stall[l] = (mv_r[l] === 1'b1) && !mr_r[l];
            prev_data[l] = d;
         end
         @(negedge clk);
      end
      sv_r = '0;
      mr_r = '0;
      for (int l = 0; l < 2; l++) begin
         total++;
         if (rcv[l] !== NR) begin bad++; $display("FAIL rnd_received lane=%0d got=%0d exp=%0d", l, rcv[l], NR); end
      end
      total++;
      if (ready_cnt * 100 < open_cnt * 45 || ready_cnt * 100 > open_cnt * 55) begin
         bad++; $display("FAIL rnd_accept_rate got=%0d/%0d exp=0.45..0.55", ready_cnt, open_cnt);
      end
   endtask

   // IN_PROB=0 blocks the lane; the stall counter saturates; enable=0 reopens it.
   task automatic test_stall();
      logic [CW-1:0] exp_sc;
      total++; if (sc_z !== '0) begin bad++; $display("FAIL stall_start got=%0d exp=0", sc_z); end
      en_z = 1'b1;
      mr_z = 1'b1;
      sv_z = 1'b1;
      sd_z = 8'h5A;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         exp_sc = StatsEn ? CW'((k > 15) ? 15 : k) : '0;
         total++; if (sr_z !== 1'b0) begin bad++; $display("FAIL stall_ready k=%0d got=%b exp=0", k, sr_z); end
         total++;
         if (sc_z !== exp_sc) begin
            bad++; $display("FAIL stall_cnt k=%0d got=%0d exp=%0d", k, sc_z, exp_sc);
         end
      end
      en_z = 1'b0;
      @(negedge clk);
      total++; if (sr_z !== 1'b1) begin bad++; $display("FAIL stall_enable_off got=%b exp=1", sr_z); end
      @(negedge clk);
      total++;
      if (mv_z !== 1'b1 || md_z !== 8'h5A) begin
         bad++; $display("FAIL stall_pass got=%b/%h exp=1/5a", mv_z, md_z);
      end
      sv_z = 1'b0;
      @(negedge clk);
      exp_sc = StatsEn ? CW'(15) : '0;
      total++; if (mv_z !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b exp=0", mv_z); end
      total++; if (sc_z !== exp_sc) begin bad++; $display("FAIL stall_final got=%0d exp=%0d", sc_z, exp_sc); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_push_pop();
      test_reset_mid();
      test_random();
      test_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
